// File: rtl/zx_mem_pkg.sv
// Shared types and widths for the ZX memory arbiter: read-return tags and bus widths.
package zx_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_CPU,
    TAG_LDR
  } tag_t;

endpackage

// File: rtl/zx_mem_rdpipe.sv
// Read-return path: a tag shift pipe aligned to RAM latency, steering mem_in to the
// requester that issued each read and holding its last read data.
module zx_mem_rdpipe
  import zx_mem_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  tag_t              issue_tag,
  input  logic [DATA_W-1:0] mem_in,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata
);

  // Stage 0 is loaded at the issue edge, so the last stage lines up with mem_in.
  tag_t              pipe [READ_LAT+1];
  logic [DATA_W-1:0] vid_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= READ_LAT; i++) pipe[i] <= TAG_NONE;
    end else begin
      pipe[0] <= issue_tag;
      for (int i = 1; i <= READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign vid_rvalid = (pipe[READ_LAT] == TAG_VID);
  assign cpu_rvalid = (pipe[READ_LAT] == TAG_CPU);
  assign ldr_rvalid = (pipe[READ_LAT] == TAG_LDR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      if (vid_rvalid) vid_rdata_q <= mem_in;
      if (cpu_rvalid) cpu_rdata_q <= mem_in;
      if (ldr_rvalid) ldr_rdata_q <= mem_in;
    end
  end

  // Data is visible in the strobe cycle itself, then held until the next read.
  assign vid_rdata = vid_rvalid ? mem_in : vid_rdata_q;
  assign cpu_rdata = cpu_rvalid ? mem_in : cpu_rdata_q;
  assign ldr_rdata = ldr_rvalid ? mem_in : ldr_rdata_q;

endmodule

// File: rtl/zx_mem_arbiter.sv
// Three-way arbiter for a single-port 64K x 8 RAM: video > cpu > loader with
// age-based overrides, registered RAM issue, and tagged read return.
module zx_mem_arbiter #(
  parameter int READ_LAT     = 1,
  parameter int CPU_MAX_WAIT = 4,
  parameter int LDR_MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_rvalid,
  output logic [7:0]  vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  output logic        ldr_rvalid,
  output logic [7:0]  ldr_rdata,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_out,
  output logic        mem_we,
  input  logic [7:0]  mem_in
);

  import zx_mem_pkg::*;

  // Handshake: a requester raises req with stable addr/we/wdata; the transfer
  // happens at the rising edge where req && ack, and the next request may follow
  // in the very next cycle.

  localparam int CPU_AW = $clog2(CPU_MAX_WAIT + 1);
  localparam int LDR_AW = $clog2(LDR_MAX_WAIT + 1);

  logic [CPU_AW-1:0] cpu_age;
  logic [LDR_AW-1:0] ldr_age;
  logic              cpu_old;
  logic              ldr_old;
  logic              grant_vid;
  logic              grant_cpu;
  logic              grant_ldr;
  tag_t              issue_tag;

  assign cpu_old = (cpu_age == CPU_AW'(CPU_MAX_WAIT));
  assign ldr_old = (ldr_age == LDR_AW'(LDR_MAX_WAIT));

  // An aged loader only overtakes the cpu; video is never overridden by it.
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    grant_ldr = 1'b0;
    if (cpu_old && cpu_req)      grant_cpu = 1'b1;
    else if (vid_req)            grant_vid = 1'b1;
    else if (ldr_old && ldr_req) grant_ldr = 1'b1;
    else if (cpu_req)            grant_cpu = 1'b1;
    else if (ldr_req)            grant_ldr = 1'b1;
  end

  assign vid_ack = grant_vid && !reset;
  assign cpu_ack = grant_cpu && !reset;
  assign ldr_ack = grant_ldr && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_age <= '0;
      ldr_age <= '0;
    end else begin
      if (cpu_ack || !cpu_req) cpu_age <= '0;
      else if (!cpu_old)       cpu_age <= cpu_age + CPU_AW'(1);
      if (ldr_ack || !ldr_req) ldr_age <= '0;
      else if (!ldr_old)       ldr_age <= ldr_age + LDR_AW'(1);
    end
  end

  // mem_address and mem_out hold through idle cycles; only mem_we drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_address <= '0;
      mem_out     <= '0;
      mem_we      <= 1'b0;
    end else if (vid_ack) begin
      mem_address <= vid_addr;
      mem_we      <= 1'b0;
    end else if (cpu_ack) begin
      mem_address <= cpu_addr;
      mem_out     <= cpu_wdata;
      mem_we      <= cpu_we;
    end else if (ldr_ack) begin
      mem_address <= ldr_addr;
      mem_out     <= ldr_wdata;
      mem_we      <= ldr_we;
    end else begin
      mem_we      <= 1'b0;
    end
  end

  always_comb begin
    issue_tag = TAG_NONE;
    if (vid_ack)                 issue_tag = TAG_VID;
    else if (cpu_ack && !cpu_we) issue_tag = TAG_CPU;
    else if (ldr_ack && !ldr_we) issue_tag = TAG_LDR;
  end

  zx_mem_rdpipe #(
    .READ_LAT (READ_LAT)
  ) u_rdpipe (
    .clock      (clock),
    .reset      (reset),
    .issue_tag  (issue_tag),
    .mem_in     (mem_in),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata)
  );

endmodule
